// File: rtl/f1_light_sequencer.sv
// F1 start-light sequencer: the lights fill one per tick, all of them hold, then they go out together with a done pulse.
// Optional macro F1_LFSR_DELAY_EN: the hold time comes from a free-running 7-bit LFSR instead of the hold_delay port.
module f1_light_sequencer #(
  parameter int N_LIGHTS = 8,
  parameter int DELAY_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  hold_delay,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                done
);
  localparam int LCW = $clog2(N_LIGHTS + 1);
  localparam logic [LCW-1:0] LC_FULL = LCW'(N_LIGHTS);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, OUT} state_t;

  state_t             state_q, state_d;
  logic [LCW-1:0]     light_cnt_q, light_cnt_d;
  logic [DELAY_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DELAY_W-1:0] hold_load;

  // Thermometer decode is done one bit wider than the bar so that a full count gives all ones.
  function automatic logic [N_LIGHTS-1:0] thermo(input logic [LCW-1:0] n);
    logic [N_LIGHTS:0] ones;
    ones = ({{N_LIGHTS{1'b0}}, 1'b1} << n) - {{N_LIGHTS{1'b0}}, 1'b1};
    return ones[N_LIGHTS-1:0];
  endfunction

`ifdef F1_LFSR_DELAY_EN
  logic [6:0] lfsr_q;

  // Runs every cycle and is left alone by abort, so the hold time depends on when the sequence started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 7'b0000001;
    else        lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  assign hold_load = DELAY_W'(lfsr_q);
`else
  assign hold_load = hold_delay;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      light_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      light_cnt_q <= light_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    light_cnt_d = light_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (abort) begin
      state_d     = IDLE;
      light_cnt_d = '0;
      hold_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d     = FILL;
            light_cnt_d = '0;
          end
        end
        FILL: begin
          if (en) begin
            light_cnt_d = light_cnt_q + 1'b1;
            if (light_cnt_q == LC_FULL - 1'b1) begin
              state_d    = HOLD;
              hold_cnt_d = hold_load;
            end
          end
        end
        HOLD: begin
          // The decrement happens only while nonzero, so the hold counter never wraps.
          if (en) begin
            if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 1'b1;
            else                  state_d    = OUT;
          end
        end
        OUT: begin
          state_d     = IDLE;
          light_cnt_d = '0;
        end
        default: begin
          state_d     = IDLE;
          light_cnt_d = '0;
          hold_cnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      FILL: begin
        data_out = thermo(light_cnt_q);
        busy     = 1'b1;
      end
      HOLD: begin
        data_out = '1;
        busy     = 1'b1;
      end
      OUT: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_f1_light_sequencer.sv
// Bench for f1_light_sequencer: a tick-count model checked on every cycle, plus directed literal sequences.
module tb_f1_light_sequencer;
  localparam int N  = 8;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] hold_delay = 7'd3;
  logic [N-1:0]  data_out;
  logic          busy, done;

  int checks = 0;
  int failures = 0;
  bit gated = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  f1_light_sequencer #(.N_LIGHTS(N), .DELAY_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trigger(trigger), .abort(abort),
    .hold_delay(hold_delay), .data_out(data_out), .busy(busy), .done(done)
  );

  always @(negedge clk) begin
    cyc++;
    en = gated ? (cyc % 4 == 0) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts en ticks since the trigger; lights = min(t, N); out once t passes N + hold.
  bit         m_act = 1'b0;
  bit         m_out = 1'b0;
  int         m_t = 0;
  int         m_h = 0;
  logic [6:0] m_lfsr = 7'd1;

  always @(posedge clk or negedge rst_n) begin
    int cap;
    if (!rst_n) begin
      m_act = 1'b0; m_out = 1'b0; m_t = 0; m_lfsr = 7'd1;
    end else begin
`ifdef F1_LFSR_DELAY_EN
      cap = int'(m_lfsr);
`else
      cap = int'(hold_delay);
`endif
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      if (abort) begin
        m_act = 1'b0; m_out = 1'b0;
      end else if (m_out) begin
        m_out = 1'b0;
      end else if (!m_act) begin
        if (trigger) begin m_act = 1'b1; m_t = 0; end
      end else if (en) begin
        m_t++;
        if (m_t == N) m_h = cap;
        if (m_t == N + m_h + 1) begin m_act = 1'b0; m_out = 1'b1; end
      end
    end
  end

  function automatic logic [N-1:0] exp_data();
    logic [63:0] v;
    if (!m_act) return '0;
    if (m_t >= N) return '1;
    v = (64'd1 << m_t) - 64'd1;
    return v[N-1:0];
  endfunction

  always @(posedge clk) begin
    #1;
    check("model_data", 32'(data_out), 32'(exp_data()));
    check("model_busy", 32'(busy), 32'(m_act | m_out));
    check("model_done", 32'(done), 32'(m_out));
  end

  logic [7:0] seq [14] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};

  initial begin
    int n01, nff, ndone, cnt;
    bit found;
    logic dsum;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_data", 32'(data_out), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_done", 32'(done), 32'h0);
    end

    // Full sequence, hold_delay=3, en every clock.
    hold_delay = 7'd3;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("seq_data", 32'(data_out), 32'(seq[i]));
      check("seq_done", 32'(done), 32'(i == 12));
      check("seq_busy", 32'(busy), 32'(i != 13));
      @(negedge clk);
    end

    // Gated ticks: en every 4th clock, hold_delay=0.
    gated = 1'b1;
    hold_delay = 7'd0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    n01 = 0; nff = 0; ndone = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (data_out == 8'h01) n01++;
      if (data_out == 8'hFF) nff++;
      if (done) begin ndone++; found = 1'b1; end
    end
    @(negedge clk);
    if (done) ndone++;
    check("gated_seen_done", 32'(found), 32'h1);
    check("gated_step_len", 32'(n01), 32'd4);
    check("gated_hold_len", 32'(nff), 32'd4);
    check("gated_done_len", 32'(ndone), 32'd1);
    check("gated_idle_busy", 32'(busy), 32'h0);
    gated = 1'b0;

    // Abort while five lights are lit.
    hold_delay = 7'd2;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (data_out == 8'h1F) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach_1f", 32'(found), 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_data", 32'(data_out), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    dsum = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      dsum = dsum | done;
    end
    check("abort_no_done", 32'(dsum), 32'h0);

    // Asynchronous reset during HOLD.
    hold_delay = 7'd5;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (data_out == 8'hFF) found = 1'b1;
    end
    check("rst_reach_hold", 32'(found), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data_out), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Trigger held through the whole sequence, through OUT, and into the following IDLE cycle.
    hold_delay = 7'd1;
    trigger = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("trig_held_len", 32'(cnt), 32'd10);
    check("trig_out_data", 32'(data_out), 32'h0);
    @(negedge clk);
    check("trig_out_ignored", 32'(busy), 32'h0);
    @(negedge clk);
    check("trig_restart_busy", 32'(busy), 32'h1);
    check("trig_restart_data", 32'(data_out), 32'h0);
    trigger = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("trig_restart_done", 32'(done), 32'h1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
